// File: rtl/gf_pkg.sv
// Shared GF(2^8) constants, FSM state type and a default-field multiply helper
// for the Horner evaluator, syndrome and Chien-search blocks.
package gf_pkg;

  localparam int GF_M = 255;
  localparam int GF_SIZE = 8;
  localparam logic [8:0] GF_PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

  // Shift-and-add multiply in the default field, folding PRIM_POLY on every carry-out
  function automatic logic [GF_SIZE-1:0] gf_mul_default(input logic [GF_SIZE-1:0] a,
                                                        input logic [GF_SIZE-1:0] b);
    logic [GF_SIZE-1:0] acc;
    logic [GF_SIZE-1:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < GF_SIZE; i++) begin
      if (b[i]) acc = acc ^ sh;
      else      acc = acc;
      if (sh[GF_SIZE-1]) sh = (sh << 1) ^ GF_PRIM_POLY[GF_SIZE-1:0];
      else               sh = sh << 1;
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^SIZE) multiplier: carry-less product reduced modulo PRIM_POLY,
// computed by iterated xtime so no intermediate exceeds SIZE bits.
module gf_mul #(
  parameter int              SIZE      = 8,
  parameter logic [SIZE:0]   PRIM_POLY = 9'h11D
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] p
);

  logic [SIZE-1:0] w_acc;
  logic [SIZE-1:0] w_sh;

  // Accumulate a*x^i terms while keeping the shifted operand reduced
  always_comb begin
    w_acc = '0;
    w_sh  = a;
    for (int i = 0; i < SIZE; i++) begin
      if (b[i]) w_acc = w_acc ^ w_sh;
      else      w_acc = w_acc;
      if (w_sh[SIZE-1]) w_sh = (w_sh << 1) ^ PRIM_POLY[SIZE-1:0];
      else              w_sh = w_sh << 1;
    end
    p = w_acc;
  end

endmodule

// File: rtl/gf_poly_eval_seq.sv
// Sequential Horner evaluator of a degree-n polynomial over GF(2^SIZE), one
// multiply per cycle, with valid/ready handshakes on both sides.
module gf_poly_eval_seq
  import gf_pkg::*;
#(
  parameter int            m         = GF_M,
  parameter int            SIZE      = $clog2(m),
  parameter int            n         = 2,
  parameter int            flat_size = (n + 1) * SIZE,
  parameter logic [SIZE:0] PRIM_POLY = GF_PRIM_POLY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [flat_size-1:0] flat_p,
  input  logic [SIZE-1:0]      x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      y,
  output logic                 busy
);

  localparam int IDX_W = (n < 1) ? 1 : $clog2(n + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(n);

  seq_state_e             r_state;
  logic [flat_size-1:0]   r_p;
  logic [SIZE-1:0]        r_x;
  logic [SIZE-1:0]        r_acc;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_out_valid;
  logic                   r_busy;
  logic [SIZE-1:0]        r_y;

  logic                   w_accept;
  logic [SIZE-1:0]        w_coef;
  logic [SIZE-1:0]        w_prod;
  logic [SIZE-1:0]        w_next_acc;

  // out_ready -> in_ready is the only combinational path through the block
  assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = r_out_valid;
  assign y          = r_y;
  assign busy       = r_busy;

  // Coefficient select by index, written as a compare loop so any n maps cleanly
  always_comb begin
    w_coef = '0;
    for (int i = 0; i <= n; i++) begin
      if (r_idx == IDX_W'(i)) w_coef = r_p[i*SIZE +: SIZE];
      else                    w_coef = w_coef;
    end
  end

  gf_mul #(
    .SIZE      (SIZE),
    .PRIM_POLY (PRIM_POLY)
  ) u_gf_mul (
    .a (r_acc),
    .b (r_x),
    .p (w_prod)
  );

  assign w_next_acc = w_prod ^ w_coef;

  // Control FSM and datapath; a HOLD handshake with in_valid restarts on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_p         <= '0;
      r_x         <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_y         <= '0;
    end else if (w_accept) begin
      r_p         <= flat_p;
      r_x         <= x;
      r_acc       <= '0;
      r_idx       <= IDX_MAX;
      r_state     <= ST_RUN;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        ST_RUN: begin
          r_acc <= w_next_acc;
          if (r_idx == '0) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_y         <= w_next_acc;
            r_busy      <= 1'b0;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_poly_eval_seq.sv
// Directed and randomized-model checks of gf_poly_eval_seq for n=2, n=0 and n=7.
module tb_gf_poly_eval_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // n=2 instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [23:0] a_flat;
  logic [7:0]  a_x, a_y;
  // n=0 instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [7:0]  b_flat;
  logic [7:0]  b_x, b_y;
  // n=7 instance
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [63:0] c_flat;
  logic [7:0]  c_x, c_y;

  gf_poly_eval_seq #(.n(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .flat_p(a_flat), .x(a_x), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .y(a_y), .busy(a_busy));

  gf_poly_eval_seq #(.n(0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .flat_p(b_flat), .x(b_x), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .y(b_y), .busy(b_busy));

  gf_poly_eval_seq #(.n(7)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .flat_p(c_flat), .x(c_x), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .y(c_y), .busy(c_busy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference multiply: full carry-less product then long division by 0x11D
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    logic [14:0] poly;
    prod = 15'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (15'({7'h00, a}) << i);
    for (int j = 14; j >= 8; j--) begin
      poly = 15'h011D << (j - 8);
      if (prod[j]) prod = prod ^ poly;
    end
    return prod[7:0];
  endfunction

  // Reference evaluation as a sum of p_i * x^i (not Horner)
  function automatic logic [7:0] ref_eval7(input logic [63:0] flat, input logic [7:0] xv);
    logic [7:0] acc;
    logic [7:0] xp;
    acc = 8'h00;
    xp  = 8'h01;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ ref_mul(flat[i*8 +: 8], xp);
      xp  = ref_mul(xp, xv);
    end
    return acc;
  endfunction

  // Waits for out_valid on DUT a with a cycle budget; returns cycles waited
  task automatic wait_a(output int cnt);
    cnt = 0;
    while (!a_out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic run_a(input string tag, input logic [23:0] flat, input logic [7:0] xv,
                       input logic [7:0] exp);
    int cnt;
    a_flat = flat; a_x = xv; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_flat = 24'hFFFFFF; a_x = 8'hFF;
    chk({tag, "_busy"}, 32'(a_busy), 32'd1);
    chk({tag, "_rdy_run"}, 32'(a_in_ready), 32'd0);
    wait_a(cnt);
    chk({tag, "_lat"}, 32'(cnt), 32'd3);
    chk({tag, "_y"}, 32'(a_y), 32'(exp));
    chk({tag, "_rdy_hold"}, 32'(a_in_ready), 32'd1);
    tick();
    chk({tag, "_ov_after"}, 32'(a_out_valid), 32'd0);
    chk({tag, "_rdy_after"}, 32'(a_in_ready), 32'd1);
  endtask

  initial begin
    int cnt;
    int spur;
    logic [63:0] rf;
    logic [7:0]  rx;
    logic [7:0]  ry;

    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_flat = 24'h0; a_x = 8'h00;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_flat = 8'h00; b_x = 8'h00;
    c_in_valid = 1'b0; c_out_ready = 1'b1; c_flat = 64'h0; c_x = 8'h00;
    tick(); tick();
    chk("rst_ov", 32'(a_out_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_y", 32'(a_y), 32'd0);
    chk("rst_rdy", 32'(a_in_ready), 32'd1);
    rst = 1'b0;
    tick();

    run_a("basic", 24'h020701, 8'h07, 8'h3E);
    run_a("reduce", 24'h010000, 8'h80, 8'h13);
    run_a("x0", 24'h020701, 8'h00, 8'h01);
    run_a("x1", 24'h020701, 8'h01, 8'h04);
    run_a("zero", 24'h000000, 8'h55, 8'h00);

    // Backpressure, then a same-edge handshake + new accept
    a_out_ready = 1'b0;
    a_flat = 24'h020701; a_x = 8'h07; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    wait_a(cnt);
    chk("bp_lat", 32'(cnt), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_y", 32'(a_y), 32'h3E);
      chk("bp_ov", 32'(a_out_valid), 32'd1);
      chk("bp_rdy", 32'(a_in_ready), 32'd0);
      tick();
    end
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_flat = 24'h020701; a_x = 8'h01;
    #1;
    chk("b2b_rdy", 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 1'b0;
    chk("b2b_ov0", 32'(a_out_valid), 32'd0);
    chk("b2b_busy", 32'(a_busy), 32'd1);
    wait_a(cnt);
    chk("b2b_lat", 32'(cnt), 32'd3);
    chk("b2b_y", 32'(a_y), 32'h04);
    tick();

    // Reset one cycle after accept aborts the job
    a_flat = 24'h020701; a_x = 8'h07; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ov", 32'(a_out_valid), 32'd0);
    chk("abort_rdy", 32'(a_in_ready), 32'd1);
    chk("abort_busy", 32'(a_busy), 32'd0);
    spur = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_out_valid) spur++;
    end
    chk("abort_spur", 32'(spur), 32'd0);

    // n=0: single RUN cycle
    b_flat = 8'h5A; b_x = 8'h33; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    cnt = 0;
    while (!b_out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("n0_lat", 32'(cnt), 32'd1);
    chk("n0_y", 32'(b_y), 32'h5A);
    tick();

    // n=7: model-checked vectors
    for (int v = 0; v < 1000; v++) begin
      rf = {$urandom(), $urandom()};
      rx = 8'($urandom_range(0, 255));
      ry = ref_eval7(rf, rx);
      c_flat = rf; c_x = rx; c_in_valid = 1'b1;
      tick();
      c_in_valid = 1'b0;
      c_flat = ~rf; c_x = ~rx;
      cnt = 0;
      while (!c_out_valid && cnt < 30) begin
        tick();
        cnt++;
      end
      chk("n7_lat", 32'(cnt), 32'd8);
      chk("n7_y", 32'(c_y), 32'(ry));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
